// File: rtl/xm_fetch_pkg.sv
// Shared types and constants for the X-Makina instruction fetch path.
package xm_fetch_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 16;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [PC_W-1:0] DEFAULT_PC_STEP  = 16'd2;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

  // Instruction words are halfword aligned; bit 0 of any loaded address is dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/program_counter_m.sv
// Program counter: aligned load has priority over increment; increment wraps mod 2^16.
module program_counter_m
  import xm_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next PC: redirect target wins over sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = align_pc(load_val);
    end else if (inc) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: reads one instruction word per request over a req/ack port,
// latches it for the decoder and tracks redirects that race in-flight reads.
module instruction_fetch_unit
  import xm_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [PC_W-1:0]   pc_load_val,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [INST_W-1:0] inst_data,
  output logic              inst_valid,
  output logic [PC_W-1:0]   pc,
  output logic              busy
);

  fetch_state_t      state_q, state_d;
  logic              flush_q, flush_d;
  logic [PC_W-1:0]   mem_addr_q, mem_addr_d;
  logic [INST_W-1:0] inst_data_q, inst_data_d;
  logic              inst_valid_q, inst_valid_d;
  logic              pc_inc;
  logic [PC_W-1:0]   pc_cur;

  // The PC only advances for an accepted word; a redirect on the ack cycle
  // takes priority and counts as a flush of that word.
  assign pc_inc = (state_q == REQ) && mem_ack && !flush_q && !pc_load;

  program_counter_m #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc_cur)
  );

  // Next-state logic: request issue, ack acceptance and flush tracking.
  always_comb begin
    state_d      = state_q;
    flush_d      = flush_q;
    mem_addr_d   = mem_addr_q;
    inst_data_d  = inst_data_q;
    inst_valid_d = inst_valid_q;
    case (state_q)
      IDLE: begin
        if (pc_load) begin
          inst_valid_d = 1'b0;
        end
        if (fetch_start) begin
          state_d      = REQ;
          flush_d      = 1'b0;
          inst_valid_d = 1'b0;
          mem_addr_d   = pc_load ? align_pc(pc_load_val) : pc_cur;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = IDLE;
          flush_d = 1'b0;
          if (!flush_q && !pc_load) begin
            inst_data_d  = mem_rdata;
            inst_valid_d = 1'b1;
          end
        end else if (pc_load) begin
          // The request stays outstanding; only its data will be dropped.
          flush_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, flush flag, address and instruction registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      flush_q      <= 1'b0;
      mem_addr_q   <= RESET_PC;
      inst_data_q  <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      mem_addr_q   <= mem_addr_d;
      inst_data_q  <= inst_data_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign mem_req    = (state_q == REQ);
  assign busy       = (state_q == REQ);
  assign mem_addr   = mem_addr_q;
  assign inst_data  = inst_data_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_cur;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: the driver acts as control unit and memory, pushes the
// expected address/result of each fetch; a monitor compares on mem_req rise
// and on busy fall.
module tb_instruction_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_STEP  = 16'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] inst_data;
  logic        inst_valid;
  logic [15:0] pc;
  logic        busy;

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_start (fetch_start),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_data   (inst_data),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic [15:0] pc;
  } res_t;

  logic [15:0] addr_q[$];
  res_t        res_q[$];

  // Architectural reference state.
  logic [15:0] m_pc;
  logic [15:0] m_data;
  logic        m_valid;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: address on request issue, result on request completion.
  logic        prev_req = 1'b0;
  logic        prev_busy = 1'b0;
  logic [15:0] exp_addr = 16'h0000;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_req && !prev_req) begin
        if (addr_q.size() == 0) begin
          check16("unexpected_req", 16'h1, 16'h0);
        end else begin
          exp_addr <= addr_q[0];
          check16("mem_addr", mem_addr, addr_q.pop_front());
        end
      end else if (mem_req && prev_req) begin
        check16("mem_addr_stable", mem_addr, exp_addr);
      end
      if (prev_busy && !busy) begin
        if (res_q.size() == 0) begin
          check16("unexpected_done", 16'h1, 16'h0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check16("inst_valid", {15'd0, inst_valid}, {15'd0, r.valid});
          check16("inst_data", inst_data, r.data);
          check16("pc", pc, r.pc);
        end
      end
    end
    prev_req  <= mem_req;
    prev_busy <= busy;
  end

  // One fetch: optional load with start, wait_n cycles before ack,
  // optional redirect at REQ cycle redir_at (== wait_n means on the ack cycle).
  task automatic do_fetch(input bit with_load, input logic [15:0] t0, input int wait_n,
                          input int redir_at, input logic [15:0] t1, input logic [15:0] data);
    logic [15:0] addr;
    res_t r;
    if (with_load) m_pc = t0 & 16'hFFFE;
    addr = m_pc;
    if (redir_at >= 0) begin
      m_pc    = t1 & 16'hFFFE;
      m_valid = 1'b0;
    end else begin
      m_data  = data;
      m_valid = 1'b1;
      m_pc    = addr + PC_STEP;
    end
    r.valid = m_valid;
    r.data  = m_data;
    r.pc    = m_pc;
    addr_q.push_back(addr);
    res_q.push_back(r);
    $display("fetch addr=%h wait=%0d redir=%0d data=%h -> valid=%0d pc=%h",
             addr, wait_n, redir_at, data, r.valid, r.pc);
    fetch_start = 1'b1;
    pc_load     = with_load;
    pc_load_val = t0;
    mem_ack     = 1'b0;
    @(negedge clk);
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    check16("busy_after_start", {15'd0, busy}, 16'h1);
    for (int k = 0; k <= wait_n; k++) begin
      mem_ack     = (k == wait_n);
      mem_rdata   = (k == wait_n) ? data : 16'($urandom);
      pc_load     = (k == redir_at);
      pc_load_val = t1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic idle_redirect(input logic [15:0] t);
    pc_load     = 1'b1;
    pc_load_val = t;
    @(negedge clk);
    pc_load = 1'b0;
    m_pc    = t & 16'hFFFE;
    m_valid = 1'b0;
    $display("idle redirect to %h", t);
    check16("idle_redir_pc", pc, m_pc);
    check16("idle_redir_valid", {15'd0, inst_valid}, 16'h0);
  endtask

  // Idle cycles with stray acks that must be ignored.
  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      mem_ack   = 1'($urandom);
      mem_rdata = 16'($urandom);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (n > 0) begin
      $display("idle gap %0d cycles", n);
      check16("gap_inst_data", inst_data, m_data);
      check16("gap_pc", pc, m_pc);
    end
  endtask

  initial begin
    m_pc    = RESET_PC;
    m_data  = 16'h0000;
    m_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check16("rst_mem_req", {15'd0, mem_req}, 16'h0);
    check16("rst_busy", {15'd0, busy}, 16'h0);
    check16("rst_mem_addr", mem_addr, RESET_PC);
    check16("rst_pc", pc, RESET_PC);
    check16("rst_inst_data", inst_data, 16'h0000);
    check16("rst_inst_valid", {15'd0, inst_valid}, 16'h0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_fetch(1'b0, 16'h0, 3, -1, 16'h0, 16'h4254);
    do_fetch(1'b0, 16'h0, 0, -1, 16'h0, 16'h1FFE);
    do_fetch(1'b0, 16'h0, 0, -1, 16'h0, 16'h0450);
    do_fetch(1'b1, 16'h0101, 1, -1, 16'h0, 16'h1234);
    do_fetch(1'b0, 16'h0, 3, 2, 16'h0200, 16'hDF1D);
    do_fetch(1'b0, 16'h0, 0, -1, 16'h0, 16'h5A5A);
    do_fetch(1'b0, 16'h0, 2, 2, 16'h0301, 16'h7777);
    idle_redirect(16'hFFFE);
    do_fetch(1'b0, 16'h0, 1, -1, 16'h0, 16'hBEEF);
    check16("wrap_pc", pc, 16'h0000);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      int w;
      int ra;
      w  = int'($urandom_range(0, 4));
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w)) : -1;
      if ($urandom_range(0, 7) == 0) idle_redirect(16'($urandom));
      do_fetch(($urandom_range(0, 4) == 0), 16'($urandom), w, ra, 16'($urandom), 16'($urandom));
      idle_gap(int'($urandom_range(0, 2)));
    end

    // Reset in the middle of an outstanding request.
    addr_q.push_back(m_pc);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    $display("reset asserted mid-request");
    check16("async_rst_mem_req", {15'd0, mem_req}, 16'h0);
    check16("async_rst_pc", pc, RESET_PC);
    check16("async_rst_valid", {15'd0, inst_valid}, 16'h0);
    m_pc    = RESET_PC;
    m_data  = 16'h0000;
    m_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 16'hCAFE;
    @(negedge clk);
    mem_ack = 1'b0;
    $display("late ack after reset");
    check16("late_ack_mem_req", {15'd0, mem_req}, 16'h0);
    check16("late_ack_pc", pc, RESET_PC);
    check16("late_ack_valid", {15'd0, inst_valid}, 16'h0);
    check16("late_ack_data", inst_data, 16'h0000);
    do_fetch(1'b0, 16'h0, 1, -1, 16'h0, 16'h0F0F);

    @(negedge clk);
    @(negedge clk);
    check16("addr_q_drained", 16'(addr_q.size()), 16'h0);
    check16("res_q_drained", 16'(res_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
